// File: rtl/conv_seq_ctrl.sv
// Sequencing controller for a 1-D convolution datapath: loads an N-sample frame into
// x memory, then walks the N-M+1 output positions driving tap addresses, accumulator control and y handshake.
module conv_seq_ctrl #(
    parameter int unsigned N  = 16,
    parameter int unsigned M  = 4,
    parameter int unsigned AX = 4,
    parameter int unsigned AF = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid_x,
    output logic          s_ready_x,
    output logic          wr_en_x,
    output logic [AX-1:0] addr_x,
    output logic [AF-1:0] addr_f,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          m_valid_y,
    input  logic          m_ready_y,
    output logic          conv_done
);

    typedef enum logic [2:0] {LOAD, CLEAR, MAC, DRAIN, OUT} state_t;

    state_t        state, state_nxt;
    logic [AX-1:0] wcnt, wcnt_nxt;
    logic [AX-1:0] out_idx, out_idx_nxt;
    logic [AF-1:0] tap, tap_nxt;
    logic          acc_en_q;
    logic          load_hs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= LOAD;
            wcnt     <= '0;
            out_idx  <= '0;
            tap      <= '0;
            acc_en_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            wcnt     <= wcnt_nxt;
            out_idx  <= out_idx_nxt;
            tap      <= tap_nxt;
            // Memory read data arrives one cycle after the address, so enable lags MAC by one.
            acc_en_q <= (state == MAC);
        end
    end

    assign acc_en = acc_en_q;

    always_comb begin
        state_nxt   = state;
        wcnt_nxt    = wcnt;
        out_idx_nxt = out_idx;
        tap_nxt     = tap;
        s_ready_x   = 1'b0;
        wr_en_x     = 1'b0;
        load_hs     = 1'b0;
        addr_x      = '0;
        addr_f      = '0;
        acc_clr     = 1'b0;
        m_valid_y   = 1'b0;
        conv_done   = 1'b0;
        case (state)
            LOAD: begin
                // The reset state is LOAD, so ready is gated to stay low while reset is held.
                s_ready_x = reset;
                load_hs   = s_valid_x & reset;
                wr_en_x   = load_hs;
                addr_x    = wcnt;
                if (load_hs) begin
                    if (wcnt == AX'(N - 1)) begin
                        wcnt_nxt  = '0;
                        state_nxt = CLEAR;
                    end else begin
                        wcnt_nxt = wcnt + 1'b1;
                    end
                end
            end
            CLEAR: begin
                acc_clr   = 1'b1;
                tap_nxt   = '0;
                state_nxt = MAC;
            end
            MAC: begin
                addr_x = out_idx + AX'(tap);
                addr_f = tap;
                if (tap == AF'(M - 1)) begin
                    tap_nxt   = '0;
                    state_nxt = DRAIN;
                end else begin
                    tap_nxt = tap + 1'b1;
                end
            end
            DRAIN: begin
                state_nxt = OUT;
            end
            OUT: begin
                m_valid_y = 1'b1;
                if (m_ready_y) begin
                    if (out_idx == AX'(N - M)) begin
                        conv_done   = 1'b1;
                        out_idx_nxt = '0;
                        state_nxt   = LOAD;
                    end else begin
                        out_idx_nxt = out_idx + 1'b1;
                        state_nxt   = CLEAR;
                    end
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: models the x/f memories and MAC around the controller and
// scoreboards each y result against hand-computed convolution values.
module tb_conv_seq_ctrl;

    localparam int N  = 16;
    localparam int M  = 4;
    localparam int AX = 4;
    localparam int AF = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid_x;
    logic          s_ready_x;
    logic          wr_en_x;
    logic [AX-1:0] addr_x;
    logic [AF-1:0] addr_f;
    logic          acc_clr;
    logic          acc_en;
    logic          m_valid_y;
    logic          m_ready_y;
    logic          conv_done;

    always #5 clk = ~clk;

    conv_seq_ctrl #(.N(N), .M(M), .AX(AX), .AF(AF)) dut (
        .clk(clk), .reset(reset), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
        .wr_en_x(wr_en_x), .addr_x(addr_x), .addr_f(addr_f), .acc_clr(acc_clr),
        .acc_en(acc_en), .m_valid_y(m_valid_y), .m_ready_y(m_ready_y), .conv_done(conv_done)
    );

    // Datapath around the controller: synchronous-read memories and one accumulator.
    int x_mem [N];
    int f_mem [M] = '{1, 2, 3, 4};
    int x_rd, f_rd, acc, s_data;

    always @(posedge clk) begin
        if (wr_en_x) x_mem[addr_x] <= s_data;
        x_rd <= x_mem[addr_x];
        f_rd <= f_mem[addr_f];
        if (acc_clr)     acc <= 0;
        else if (acc_en) acc <= acc + x_rd * f_rd;
    end

    typedef struct { int y; bit done; } exp_t;
    exp_t sb[$];
    exp_t e;
    int total = 0, bad = 0, wr_cnt = 0, done_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en_x)   wr_cnt++;
        if (conv_done) done_cnt++;
        if (reset && m_valid_y && m_ready_y) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_y: got y=%0d expected no output", acc);
            end else begin
                e = sb.pop_front();
                check("y_value", acc, e.y);
                check("y_conv_done", int'(conv_done), int'(e.done));
            end
        end
    end

    task automatic load_frame(input int base, input int step, input int gaps);
        for (int i = 0; i < N; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gaps; g++) begin
                    s_valid_x = 1'b0;
                    @(negedge clk);
                    check("gap_wr_en", int'(wr_en_x), 0);
                    check("gap_addr_x", int'(addr_x), i);
                    @(posedge clk); #1;
                end
            end
            s_valid_x = 1'b1;
            s_data    = base + step * i;
            @(negedge clk);
            check("ld_ready", int'(s_ready_x), 1);
            check("ld_wr_en", int'(wr_en_x), 1);
            check("ld_addr_x", int'(addr_x), i);
            @(posedge clk); #1;
        end
    endtask

    // Walks one output position starting in the CLEAR cycle.
    task automatic walk(input int k, input int exp_y, input bit stall, input bit rst_mid);
        if (!rst_mid) sb.push_back('{y: exp_y, done: (k == N - M)});
        @(negedge clk);
        check("clr_acc_clr", int'(acc_clr), 1);
        check("clr_acc_en", int'(acc_en), 0);
        check("clr_ready", int'(s_ready_x), 0);
        check("clr_wr_en", int'(wr_en_x), 0);
        @(posedge clk); #1;
        for (int t = 0; t < M; t++) begin
            @(negedge clk);
            check("mac_addr_x", int'(addr_x), k + t);
            check("mac_addr_f", int'(addr_f), t);
            check("mac_acc_en", int'(acc_en), (t != 0) ? 1 : 0);
            check("mac_acc_clr", int'(acc_clr), 0);
            check("mac_wr_en", int'(wr_en_x), 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("drain_acc_en", int'(acc_en), 1);
        check("drain_valid", int'(m_valid_y), 0);
        if (stall || rst_mid) m_ready_y = 1'b0;
        if (k == N - M) s_valid_x = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("out_valid", int'(m_valid_y), 1);
        check("out_acc_en", int'(acc_en), 0);
        if (rst_mid) begin
            #2 reset = 1'b0;
            #1;
            check("rst_async_valid", int'(m_valid_y), 0);
            check("rst_ready", int'(s_ready_x), 0);
            repeat (3) begin
                @(negedge clk);
                check("rst_hold_ready", int'(s_ready_x), 0);
                check("rst_hold_valid", int'(m_valid_y), 0);
                check("rst_hold_addr_x", int'(addr_x), 0);
            end
            @(posedge clk); #1;
            reset     = 1'b1;
            m_ready_y = 1'b1;
            return;
        end
        if (stall) begin
            for (int c = 0; c < 10; c++) begin
                if (c > 0) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                end
                check("stall_valid", int'(m_valid_y), 1);
                check("stall_acc_en", int'(acc_en), 0);
                check("stall_acc_clr", int'(acc_clr), 0);
                check("stall_addr_x", int'(addr_x), 0);
                check("stall_addr_f", int'(addr_f), 0);
                check("stall_done", int'(conv_done), 0);
            end
            @(posedge clk); #1;
            m_ready_y = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        s_valid_x = 1'b1;
        m_ready_y = 1'b1;
        s_data    = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", int'(s_ready_x), 0);
        check("rst_wr_en", int'(wr_en_x), 0);
        check("rst_m_valid", int'(m_valid_y), 0);
        check("rst_addr_x", int'(addr_x), 0);
        check("rst_addr_f", int'(addr_f), 0);
        check("rst_acc_en", int'(acc_en), 0);
        check("rst_acc_clr", int'(acc_clr), 0);
        check("rst_conv_done", int'(conv_done), 0);
        s_valid_x = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        // Frame 1: x[i]=i+1, f={1,2,3,4} -> y[k]=30+10k; output 2 is stalled 10 cycles.
        load_frame(1, 1, 0);
        check("frame1_writes", wr_cnt, 16);
        for (int k = 0; k <= N - M; k++) walk(k, 30 + 10 * k, k == 2, 1'b0);

        // Frame 2 starts right after conv_done; x[i]=16-i with 1,0,0 valid pattern -> y[k]=140-10k.
        load_frame(16, -1, 2);
        for (int k = 0; k <= N - M; k++) walk(k, 140 - 10 * k, 1'b0, 1'b0);
        check("frame2_writes", wr_cnt, 32);

        // Frame 3 is abandoned by a reset during its first OUT.
        load_frame(5, 0, 0);
        walk(0, 0, 1'b0, 1'b1);
        s_valid_x = 1'b1;
        s_data    = 99;
        @(negedge clk);
        check("post_rst_ready", int'(s_ready_x), 1);
        check("post_rst_wr_en", int'(wr_en_x), 1);
        check("post_rst_addr_x", int'(addr_x), 0);
        @(posedge clk); #1;
        s_valid_x = 1'b0;
        @(negedge clk);
        check("post_rst_next_addr", int'(addr_x), 1);
        check("post_rst_mem0", x_mem[0], 99);

        check("done_pulses", done_cnt, 2);
        check("sb_empty", sb.size(), 0);
        check("total_writes", wr_cnt, 49);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
